bg_mem_arbiter: RTL and testbench
=================================

Name: bg_mem_arbiter

Overview:
- Shares one single-port background/scoreboard memory (19-bit address, 320x480 map plus two 320x240 score panels) among three requesters: the display fetch path, a game-logic reader used for collision and tile lookups, and a scoreboard writer that updates score panels.
- The display owns the memory during the visible region.
- The game reader and the scoreboard writer are round-robin arbitrated during blanking.
- Sits between the background address generator and the memory; routes read data back to its owner through a latency-matched tag pipeline.

Parameters:
- ADDR_W, 19, memory address width.
- DATA_W, 8, memory word (palette index) width.
- READ_LAT, 1, memory read latency in cycles; legal values 1..3.
- H_VISIBLE, 640, first non-visible DrawX.
- V_VISIBLE, 480, first non-visible DrawY.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- disp_addr  in  ADDR_W  display fetch address from the background address generator.
- disp_data  out  DATA_W  display read data.
- disp_valid  out  1  disp_data valid.
- rd_req  in  1  game-reader request; held with rd_addr stable until rd_ack.
- rd_addr  in  ADDR_W  game-reader address.
- rd_ack  out  1  one-cycle pulse: the read is issued this cycle.
- rd_data  out  DATA_W  game-reader data.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- wr_req  in  1  writer request; held with wr_addr/wr_data stable until wr_ack.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle pulse: the write is committed this cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, READ_LAT cycles after the address.

Behaviour:
- active = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE). Evaluated combinationally each cycle from the current inputs.
- FSM states:
  - DISP: active=1. mem_addr=disp_addr, mem_we=0, tag=DISP. rd_ack=wr_ack=0 regardless of requests.
  - BLANK: active=0. If exactly one of rd_req/wr_req is set, grant it. If both are set, grant the side named by rr_ptr. If neither, mem_addr=0, mem_we=0, tag=NONE.
- Transitions: DISP->BLANK on the first cycle with active=0; BLANK->DISP on the first cycle with active=1. The transition cycle uses the new state's rules, so there are no dead cycles.
- Read grant: mem_addr=rd_addr, rd_ack=1, tag=RD.
- Write grant: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data, wr_ack=1, tag=NONE (no data returns).
- rr_ptr:
  - 1 bit; reset value selects the writer.
  - Toggles to the other requester only on a grant made while both requests are set.
  - Otherwise holds.
- Tag pipeline:
  - A 2-bit tag shifts through READ_LAT registers.
  - When the tag emerges:
    - DISP: disp_valid=1, disp_data=mem_rdata.
    - RD: rd_valid=1, rd_data=mem_rdata.
  - The *_data outputs hold their last value otherwise.
- Latency:
  - Display: disp_data for the address presented at cycle t appears at t+READ_LAT.
  - Game reader: rd_valid at t+READ_LAT after the rd_ack cycle t.
- Pipelining: one access per cycle, with no bubbles between back-to-back grants.
- Request rule: a requester may deassert req only after ack. Dropping req before ack cancels the request with no side effects.
- Read-after-write: a read granted at t+1 after a write at t to the same address returns the new data.
- Starvation bound: with both requests continuously asserted during blanking, grants alternate W,R,W,R...
- Reset (any cycle, including mid-transfer):
  - Next cycle: all outputs 0, tag pipeline = NONE, rr_ptr = writer.
  - In-flight reads are dropped: no rd_valid or disp_valid emerges for accesses issued before Reset.
  - mem_we=0 while Reset is high.

Test Plan:
1. Reset mid-read: rd_ack at t, Reset at t+1 (READ_LAT=2) -> no rd_valid at t+2 or t+3; all outputs 0 at t+2.
2. Active region priority: DrawX=100, DrawY=50, disp_addr=16100, rd_req=wr_req=1 -> mem_addr=16100, mem_we=0, no acks; disp_valid with mem_rdata at +READ_LAT.
3. Blank contention: DrawX=700, both requests held for 4 cycles -> wr_ack, rd_ack, wr_ack, rd_ack; rr_ptr alternates.
4. Read-after-write: write 0x5A to 153600 at t, then read 153600 -> rd_ack at t+1, rd_valid with 0x5A at t+1+READ_LAT.
5. Boundary: DrawX steps 639->640 with DrawY=10 and rd_req held -> no ack at 639, rd_ack at 640. DrawX=799->0 with DrawY=479 -> display owns at 0, no game ack.
6. Single requester: only rd_req in blank, 3 back-to-back reads -> rd_ack on 3 consecutive cycles, 3 consecutive rd_valid pulses, rr_ptr unchanged.

Source files
------------

// File: rtl/bg_mem_arbiter.sv
// Single-port background/scoreboard memory arbiter: display owns the port while visible,
// game reader and score writer share it round-robin in blanking. Read data is routed by a tag pipeline.
module bg_mem_arbiter #(
   parameter int ADDR_W    = 19,
   parameter int DATA_W    = 8,
   parameter int READ_LAT  = 1,
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
   localparam logic       RR_WR = 1'b0;
   localparam logic       RR_RD = 1'b1;

   typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_RD} tag_t;
   typedef enum logic {ST_DISP, ST_BLANK} state_t;

   state_t            state, state_nxt;
   logic              active;
   logic              rr_ptr, rr_nxt;
   logic              gnt_wr, gnt_rd;
   tag_t              tag_s0;
   tag_t              tag_pipe [1:READ_LAT];
   logic [DATA_W-1:0] disp_hold, rd_hold;

   assign active = (DrawX < H_VIS) && (DrawY < V_VIS);

   // Outputs follow state_nxt so the transition cycle already obeys the new state's rules.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_DISP:  if (!active) state_nxt = ST_BLANK;
         ST_BLANK: if (active)  state_nxt = ST_DISP;
      endcase

      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      rd_ack    = 1'b0;
      wr_ack    = 1'b0;
      gnt_wr    = 1'b0;
      gnt_rd    = 1'b0;
      tag_s0    = TAG_NONE;
      rr_nxt    = rr_ptr;
      if (!Reset) begin
         case (state_nxt)
            ST_DISP: begin
               mem_addr = disp_addr;
               tag_s0   = TAG_DISP;
            end
            ST_BLANK: begin
               gnt_wr = wr_req && (!rd_req || (rr_ptr == RR_WR));
               gnt_rd = rd_req && !gnt_wr;
               if (rd_req && wr_req) rr_nxt = gnt_wr ? RR_RD : RR_WR;
               if (gnt_wr) begin
                  mem_addr  = wr_addr;
                  mem_we    = 1'b1;
                  mem_wdata = wr_data;
                  wr_ack    = 1'b1;
               end else if (gnt_rd) begin
                  mem_addr = rd_addr;
                  rd_ack   = 1'b1;
                  tag_s0   = TAG_RD;
               end
            end
         endcase
      end
   end

   // Valids are masked during Reset so nothing issued before it ever emerges.
   assign disp_valid = !Reset && (tag_pipe[READ_LAT] == TAG_DISP);
   assign rd_valid   = !Reset && (tag_pipe[READ_LAT] == TAG_RD);
   assign disp_data  = disp_valid ? mem_rdata : disp_hold;
   assign rd_data    = rd_valid   ? mem_rdata : rd_hold;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= ST_DISP;
         rr_ptr    <= RR_WR;
         disp_hold <= '0;
         rd_hold   <= '0;
         for (int i = 1; i <= READ_LAT; i++) tag_pipe[i] <= TAG_NONE;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_nxt;
         disp_hold <= disp_data;
         rd_hold   <= rd_data;
         tag_pipe[1] <= tag_s0;
         for (int i = 2; i <= READ_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Randomized + directed bench for bg_mem_arbiter against a transaction-level reference model.
module tb_bg_mem_arbiter;
   localparam int AW = 19;
   localparam int DW = 8;
   localparam int RL = 2;

   logic          Clk = 1'b0;
   logic          Reset;
   logic [9:0]    DrawX, DrawY;
   logic [AW-1:0] disp_addr, rd_addr, wr_addr, mem_addr;
   logic [DW-1:0] disp_data, rd_data, wr_data, mem_wdata, mem_rdata;
   logic          disp_valid, rd_req, rd_ack, rd_valid, wr_req, wr_ack, mem_we;

   always #5 Clk = ~Clk;

   bg_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .H_VISIBLE(640), .V_VISIBLE(480)) dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
      .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // unwritten locations return a fixed address-derived pattern
   function automatic logic [DW-1:0] fill(logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // behavioural single-port memory with RL-cycle read latency
   logic [DW-1:0] mem [int];
   logic [DW-1:0] rpipe [RL];
   always @(posedge Clk) begin
      logic [DW-1:0] rv;
      rv = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : fill(mem_addr);
      for (int i = RL-1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      rpipe[0] <= rv;
      if (mem_we) mem[int'(mem_addr)] = mem_wdata;
   end
   assign mem_rdata = rpipe[RL-1];

   // reference model state
   typedef struct { int due; bit is_rd; logic [DW-1:0] data; } ret_t;
   logic [DW-1:0] ref_mem [int];
   ret_t          pend [$];
   int            cyc = 0, checks = 0, errors = 0;
   bit            prefer_wr = 1'b1, inited = 1'b0;
   logic [DW-1:0] hold_d = '0, hold_r = '0;
   bit            e_rd_ack, e_wr_ack;
   logic          s_rd_ack, s_wr_ack, s_rd_valid, s_disp_valid, s_mem_we;
   logic [DW-1:0] s_rd_data, s_disp_data, s_mem_wdata;
   logic [AW-1:0] s_mem_addr;

   function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill(a);
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // one clock: compare DUT against model at the negedge, then advance the model
   task automatic step();
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd, ed_d, ed_r;
      bit            ewe, ev_d, ev_r, act, gw, gr;
      @(negedge Clk);
      s_rd_ack = rd_ack; s_wr_ack = wr_ack; s_rd_valid = rd_valid; s_disp_valid = disp_valid;
      s_rd_data = rd_data; s_disp_data = disp_data; s_mem_addr = mem_addr; s_mem_we = mem_we;
      s_mem_wdata = mem_wdata;
      ea = '0; ewe = 0; ewd = '0; gw = 0; gr = 0; e_rd_ack = 0; e_wr_ack = 0;
      ev_d = 0; ev_r = 0; ed_d = hold_d; ed_r = hold_r;
      if (!Reset) begin
         foreach (pend[i]) if (pend[i].due == cyc) begin
            if (pend[i].is_rd) begin ev_r = 1; ed_r = pend[i].data; end
            else begin ev_d = 1; ed_d = pend[i].data; end
         end
         act = (DrawX < 10'd640) && (DrawY < 10'd480);
         if (act) begin
            ea = disp_addr;
            pend.push_back('{due: cyc+RL, is_rd: 1'b0, data: ref_rd(disp_addr)});
         end else begin
            gw = wr_req && (!rd_req || prefer_wr);
            gr = rd_req && !gw;
            if (wr_req && rd_req) prefer_wr = gr;
            if (gw) begin ea = wr_addr; ewe = 1; ewd = wr_data; e_wr_ack = 1; end
            else if (gr) begin
               ea = rd_addr; e_rd_ack = 1;
               pend.push_back('{due: cyc+RL, is_rd: 1'b1, data: ref_rd(rd_addr)});
            end
         end
      end
      chk("mem_addr", 32'(s_mem_addr), 32'(ea));
      chk("mem_we", 32'(s_mem_we), 32'(ewe));
      if (ewe || Reset) chk("mem_wdata", 32'(s_mem_wdata), 32'(ewd));
      chk("rd_ack", 32'(s_rd_ack), 32'(e_rd_ack));
      chk("wr_ack", 32'(s_wr_ack), 32'(e_wr_ack));
      chk("disp_valid", 32'(s_disp_valid), 32'(ev_d));
      chk("rd_valid", 32'(s_rd_valid), 32'(ev_r));
      if (inited) begin
         chk("disp_data", 32'(s_disp_data), 32'(ed_d));
         chk("rd_data", 32'(s_rd_data), 32'(ed_r));
      end
      if (gw) ref_mem[int'(wr_addr)] = wr_data;
      if (Reset) begin
         pend.delete(); hold_d = '0; hold_r = '0; prefer_wr = 1'b1; inited = 1'b1;
      end else begin
         hold_d = ed_d; hold_r = ed_r;
         for (int i = pend.size()-1; i >= 0; i--) if (pend[i].due <= cyc) pend.delete(i);
      end
      cyc++;
      @(posedge Clk);
      #1;
   endtask

   int nval;

   initial begin
      Reset = 1; DrawX = 10'd700; DrawY = 10'd10; disp_addr = '0;
      rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
      @(posedge Clk); #1;
      step(); step();
      Reset = 0;

      // visible region: display owns the port despite both requests
      DrawX = 10'd100; DrawY = 10'd50; disp_addr = 19'd16100;
      rd_req = 1; rd_addr = 19'd5; wr_req = 1; wr_addr = 19'd6; wr_data = 8'h11;
      step();
      chk("t2_addr", 32'(s_mem_addr), 32'd16100);
      chk("t2_acks", 32'({s_wr_ack, s_rd_ack}), 32'd0);
      step(); step();
      chk("t2_disp_valid", 32'(s_disp_valid), 32'd1);
      chk("t2_disp_data", 32'(s_disp_data), 32'(fill(19'd16100)));

      // blanking contention: writer first, then alternation
      DrawX = 10'd700;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t3_seq", 32'({s_wr_ack, s_rd_ack}), (i % 2 == 0) ? 32'd2 : 32'd1);
         if (s_wr_ack) wr_addr = wr_addr + 19'd1;
         if (s_rd_ack) rd_addr = rd_addr + 19'd1;
      end
      rd_req = 0; wr_req = 0;
      step(); step();

      // read-after-write on a score-panel address
      wr_req = 1; wr_addr = 19'd153600; wr_data = 8'h5A;
      step();
      chk("t4_wr_ack", 32'(s_wr_ack), 32'd1);
      wr_req = 0; rd_req = 1; rd_addr = 19'd153600;
      step();
      chk("t4_rd_ack", 32'(s_rd_ack), 32'd1);
      rd_req = 0;
      step(); step();
      chk("t4_rd_valid", 32'(s_rd_valid), 32'd1);
      chk("t4_rd_data", 32'(s_rd_data), 32'h5A);

      // visible/blank boundaries
      DrawY = 10'd10; DrawX = 10'd639; rd_req = 1; rd_addr = 19'd77;
      step();
      chk("t5_639", 32'(s_rd_ack), 32'd0);
      DrawX = 10'd640;
      step();
      chk("t5_640", 32'(s_rd_ack), 32'd1);
      rd_req = 0; DrawY = 10'd479; DrawX = 10'd799;
      step();
      DrawX = 10'd0; disp_addr = 19'd1234; rd_req = 1;
      step();
      chk("t5_wrap_ack", 32'(s_rd_ack), 32'd0);
      chk("t5_wrap_addr", 32'(s_mem_addr), 32'd1234);
      rd_req = 0; DrawX = 10'd700;
      step(); step(); step();

      // single requester: back-to-back reads, pointer untouched
      nval = 0;
      rd_req = 1; rd_addr = 19'd300;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i < 3) begin
            chk("t6_ack", 32'(s_rd_ack), 32'd1);
            rd_addr = rd_addr + 19'd1;
         end
         if (i == 2) rd_req = 0;
         if (s_rd_valid) nval++;
      end
      chk("t6_nvalid", 32'(nval), 32'd3);
      rd_req = 1; wr_req = 1; wr_addr = 19'd400; wr_data = 8'h33;
      step();
      chk("t6_rr_wr_first", 32'({s_wr_ack, s_rd_ack}), 32'd2);
      rd_req = 0; wr_req = 0;
      step();

      // reset in the middle of a read
      rd_req = 1; rd_addr = 19'd9;
      step();
      chk("t1_ack", 32'(s_rd_ack), 32'd1);
      rd_req = 0; Reset = 1;
      step();
      step();
      chk("t1_flags", 32'({s_disp_valid, s_rd_valid, s_rd_ack, s_wr_ack, s_mem_we}), 32'd0);
      chk("t1_data", 32'({s_disp_data, s_rd_data, s_mem_wdata}), 32'd0);
      chk("t1_addr", 32'(s_mem_addr), 32'd0);
      Reset = 0;
      step();
      chk("t1_no_valid", 32'(s_rd_valid), 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         Reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) begin
            DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479));
         end else if ($urandom_range(0, 1) == 0) begin
            DrawX = 10'($urandom_range(640, 799)); DrawY = 10'($urandom_range(0, 524));
         end else begin
            DrawX = 10'($urandom_range(0, 799)); DrawY = 10'($urandom_range(480, 524));
         end
         disp_addr = 19'($urandom_range(0, 63));
         if (!rd_req || e_rd_ack) begin
            rd_req = ($urandom_range(0, 2) != 0); rd_addr = 19'($urandom_range(0, 31));
         end else if ($urandom_range(0, 29) == 0) rd_req = 0;
         if (!wr_req || e_wr_ack) begin
            wr_req = ($urandom_range(0, 2) != 0); wr_addr = 19'($urandom_range(0, 31));
            wr_data = 8'($urandom);
         end else if ($urandom_range(0, 29) == 0) wr_req = 0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
